// File: rtl/disp_pkg.sv
// Shared constants, state encoding and digit helpers for the display arbiter.
package disp_pkg;

  localparam logic [3:0]  BLANK_DIGIT = 4'hF;
  localparam logic [31:0] BLANK_WORD  = {8{BLANK_DIGIT}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  // Nibble 7 is the leftmost digit, nibble 0 the rightmost.
  function automatic logic [3:0] nibble(input logic [31:0] word, input int unsigned idx);
    return word[4*idx +: 4];
  endfunction

endpackage

// File: rtl/disp_prio_enc.sv
// Combinational fixed-priority encoder; the highest set index wins.
module disp_prio_enc #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    idx
);

  always_comb begin
    valid  = |req;
    idx    = '0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = IW'(i);
    end
    if (valid) winner[idx] = 1'b1;
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 8-digit display between prioritised requesters with a minimum hold
// time and optional per-owner blinking; all outputs are registered.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_digits,
  input  logic [N_REQ-1:0]     req_blink,
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           display7,
  output logic [3:0]           display6,
  output logic [3:0]           display5,
  output logic [3:0]           display4,
  output logic [3:0]           display3,
  output logic [3:0]           display2,
  output logic [3:0]           display1,
  output logic [3:0]           display0
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [HW-1:0]     hold_q, hold_d, hold_inc;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [31:0]       dig_q, dig_d;
  logic [31:0]       disp_q, disp_d;

  logic              win_valid;
  logic [N_REQ-1:0]  win_onehot;
  logic [IW-1:0]     win_idx;
  logic              hold_done, owner_req, take_new;

  disp_prio_enc #(
    .N_REQ (N_REQ)
  ) u_prio_enc (
    .req    (req),
    .valid  (win_valid),
    .winner (win_onehot),
    .idx    (win_idx)
  );

  assign hold_done = (hold_q == HW'(HOLD_CYCLES - 1));
  assign hold_inc  = hold_done ? hold_q : hold_q + HW'(1);
  assign owner_req = req[owner_q];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    hold_d      = hold_q;
    dig_d       = dig_q;
    take_new    = 1'b0;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    disp_d      = BLANK_WORD;

    unique case (state_q)
      IDLE: begin
        if (win_valid) take_new = 1'b1;
      end
      OWN: begin
        if (owner_req) begin
          if (hold_done && (win_idx > owner_q)) begin
            take_new = 1'b1;
          end else begin
            hold_d = hold_inc;
            dig_d  = req_digits[32*owner_q +: 32];
          end
        end else if (hold_done) begin
          if (win_valid) take_new = 1'b1;
          else           state_d  = IDLE;
        end else begin
          state_d = FROZEN;
          grant_d = '0;
          hold_d  = hold_inc;
        end
      end
      FROZEN: begin
        if (hold_done) begin
          if (win_valid) take_new = 1'b1;
          else           state_d  = IDLE;
        end else if (owner_req) begin
          // Owner came back inside its hold window: resume without restarting hold.
          state_d          = OWN;
          grant_d          = '0;
          grant_d[owner_q] = 1'b1;
          hold_d           = hold_inc;
          dig_d            = req_digits[32*owner_q +: 32];
        end else begin
          hold_d = hold_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_new) begin
      state_d = OWN;
      owner_d = win_idx;
      grant_d = win_onehot;
      hold_d  = '0;
      dig_d   = req_digits[32*win_idx +: 32];
    end

    if (state_d == IDLE) begin
      grant_d = '0;
      hold_d  = '0;
    end

    if ((state_d == IDLE) || take_new || !req_blink[owner_d]) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    if ((state_d != IDLE) && phase_d) disp_d = dig_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      grant_q     <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      dig_q       <= BLANK_WORD;
      disp_q      <= BLANK_WORD;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      dig_q       <= dig_d;
      disp_q      <= disp_d;
    end
  end

  assign grant    = grant_q;
  assign display7 = nibble(disp_q, 7);
  assign display6 = nibble(disp_q, 6);
  assign display5 = nibble(disp_q, 5);
  assign display4 = nibble(disp_q, 4);
  assign display3 = nibble(disp_q, 3);
  assign display2 = nibble(disp_q, 2);
  assign display1 = nibble(disp_q, 1);
  assign display0 = nibble(disp_q, 0);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a queue-based scoreboard of expected outputs.
module tb_display_arbiter;

  localparam logic [31:0] D0 = 32'h1234_5678;
  localparam logic [31:0] D1 = 32'h8765_4321;
  localparam logic [31:0] D2 = 32'h2468_0135;
  localparam logic [31:0] BL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  req_blink;
  logic [31:0] dig0, dig1, dig2;
  logic [95:0] req_digits;
  logic [2:0]  grant;
  logic [3:0]  display7, display6, display5, display4;
  logic [3:0]  display3, display2, display1, display0;

  typedef struct packed {
    logic [2:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    total = 0;
  int    bad   = 0;

  assign req_digits = {dig2, dig1, dig0};

  always #5 clk = ~clk;

  display_arbiter #(
    .N_REQ       (3),
    .HOLD_CYCLES (4),
    .BLINK_HALF  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_digits (req_digits),
    .req_blink  (req_blink),
    .grant      (grant),
    .display7   (display7),
    .display6   (display6),
    .display5   (display5),
    .display4   (display4),
    .display3   (display3),
    .display2   (display2),
    .display1   (display1),
    .display0   (display0)
  );

  // Push the expectation for the coming edge, advance one cycle, then pop and compare.
  task automatic tick(input logic [2:0] eg, input logic [31:0] ed, input string tag);
    exp_t        e;
    string       t;
    logic [31:0] obs;
    sb.push_back('{g: eg, d: ed});
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    t   = sb_tag.pop_front();
    obs = {display7, display6, display5, display4, display3, display2, display1, display0};
    total++;
    assert (grant === e.g) else begin
      bad++;
      $error("FAIL %s grant: got %b want %b", t, grant, e.g);
    end
    total++;
    assert (obs === e.d) else begin
      bad++;
      $error("FAIL %s display: got %h want %h", t, obs, e.d);
    end
  endtask

  task automatic do_reset(input logic [2:0] r);
    rst_n     = 1'b0;
    req       = r;
    req_blink = 3'b000;
    tick(3'b000, BL, "reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 3'b111; req_blink = 3'b000;
    dig0 = D0; dig1 = D1; dig2 = D2;
    #1;

    // Reset held two cycles with all requests high.
    tick(3'b000, BL, "rst_a");
    tick(3'b000, BL, "rst_b");
    rst_n = 1'b1;
    tick(3'b100, D2, "rst_release");

    // Single owner and digit tracking.
    do_reset(3'b000);
    tick(3'b000, BL, "idle");
    req = 3'b001;
    tick(3'b001, D0, "single_own");
    dig0 = 32'h0000_0009;
    tick(3'b001, 32'h0000_0009, "single_track");
    dig0 = D0;
    tick(3'b001, D0, "single_back");

    // Preemption only after hold expires; lower index never preempts.
    do_reset(3'b001);
    tick(3'b001, D0, "pre_e0");
    tick(3'b001, D0, "pre_e1");
    req = 3'b101;
    tick(3'b001, D0, "pre_e2");
    tick(3'b001, D0, "pre_e3");
    tick(3'b100, D2, "pre_switch");
    req = 3'b111;
    for (int i = 0; i < 5; i++) tick(3'b100, D2, "pre_low");
    req = 3'b110;
    tick(3'b100, D2, "pre_low_only");

    // Early drop freezes digits until hold expires, then blanks.
    do_reset(3'b001);
    tick(3'b001, D0, "drop_own");
    req = 3'b000;
    tick(3'b000, D0, "drop_fz1");
    tick(3'b000, D0, "drop_fz2");
    tick(3'b000, D0, "drop_fz3");
    tick(3'b000, BL, "drop_idle");
    tick(3'b000, BL, "drop_idle2");

    // Re-raise inside hold window resumes without a blank and without restarting hold.
    do_reset(3'b001);
    tick(3'b001, D0, "rr_own");
    req = 3'b000;
    tick(3'b000, D0, "rr_frozen");
    req = 3'b001; dig0 = 32'h9999_0000;
    tick(3'b001, 32'h9999_0000, "rr_resume");
    req = 3'b101;
    tick(3'b001, 32'h9999_0000, "rr_hold");
    tick(3'b100, D2, "rr_preempt");
    dig0 = D0;

    // Handover after hold with no blank cycle, then release to idle.
    do_reset(3'b001);
    tick(3'b001, D0, "ho_e0");
    tick(3'b001, D0, "ho_e1");
    tick(3'b001, D0, "ho_e2");
    tick(3'b001, D0, "ho_e3");
    req = 3'b010;
    tick(3'b010, D1, "ho_switch");
    tick(3'b010, D1, "ho_h1");
    tick(3'b010, D1, "ho_h2");
    tick(3'b010, D1, "ho_h3");
    req = 3'b000;
    tick(3'b000, BL, "ho_idle");

    // Blink: three on, three off; grant change during off shows digits at once.
    do_reset(3'b001);
    req_blink = 3'b001;
    for (int c = 0; c < 10; c++) tick(3'b001, ((c % 6) < 3) ? D0 : BL, "blink0");
    req = 3'b011;
    tick(3'b010, D1, "blink_switch");
    req_blink = 3'b010;
    tick(3'b010, D1, "blink1_on1");
    tick(3'b010, D1, "blink1_on2");
    tick(3'b010, BL, "blink1_off0");
    tick(3'b010, BL, "blink1_off1");
    tick(3'b010, BL, "blink1_off2");
    tick(3'b010, D1, "blink1_on0");
    rst_n = 1'b0;
    tick(3'b000, BL, "blink_reset");
    rst_n = 1'b1; req = 3'b000;
    tick(3'b000, BL, "blink_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
